// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared constants and FSM encoding for the UART command sequencer
package uart_cmd_pkg;

  // Control bytes recognised in the incoming character stream
  localparam logic [7:0] ESC_BYTE   = 8'h1B;
  localparam logic [7:0] R_BYTE     = 8'h52;
  localparam logic [7:0] C_BYTE     = 8'h43;
  localparam logic [7:0] K_BYTE     = 8'h4B;
  localparam logic [7:0] SPACE_BYTE = 8'h20;

  // Display geometry after reset
  localparam logic [7:0] DEFAULT_ROWS = 8'h80;
  localparam logic [7:0] DEFAULT_COLS = 8'hA0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ESC,
    ST_ARG_R,
    ST_ARG_C,
    ST_CLEAR
  } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - small synchronous byte FIFO buffering received UART characters
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_rd;
  logic             do_wr;

  // A write into a full FIFO is still taken when the head leaves in the same cycle
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign rd_data_o = mem_q[rd_ptr_q];

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - forwards UART characters and decodes ESC geometry/clear commands
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] DEF_ROWS   = DEFAULT_ROWS,
  parameter logic [7:0] DEF_COLS   = DEFAULT_COLS
) (
  input  logic       CLK_50MHz,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_en,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_en,
  output logic [7:0] max_rows,
  output logic [7:0] max_columns,
  output logic       row_column_update,
  output logic       overflow,
  output logic       busy
);

  state_t      state_q;
  logic [7:0]  out_data_q;
  logic        out_en_q;
  logic [7:0]  rows_q;
  logic [7:0]  cols_q;
  logic        update_q;
  logic        overflow_q;
  logic [15:0] clr_cnt_q;

  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_byte;
  logic        pop;

  // The FIFO is frozen while a clear is streaming spaces so buffered text follows the clear
  assign pop = !fifo_empty && (state_q != ST_CLEAR) && out_ready;

  cmd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk_i    (CLK_50MHz),
    .reset_i  (reset),
    .wr_en_i  (rx_en),
    .wr_data_i(rx_data),
    .rd_en_i  (pop),
    .rd_data_o(fifo_byte),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // Sticky record of any byte lost because the FIFO had no room
  always_ff @(posedge CLK_50MHz or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (rx_en && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  // Command decoder: consumes one popped byte per cycle or emits one clear space
  always_ff @(posedge CLK_50MHz or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      out_data_q <= 8'h00;
      out_en_q   <= 1'b0;
      rows_q     <= DEF_ROWS;
      cols_q     <= DEF_COLS;
      update_q   <= 1'b0;
      clr_cnt_q  <= 16'd0;
    end else begin
      out_en_q <= 1'b0;
      update_q <= 1'b0;
      if (state_q == ST_CLEAR) begin
        if (clr_cnt_q == 16'd0) begin
          state_q <= ST_IDLE;
        end else if (out_ready) begin
          out_en_q   <= 1'b1;
          out_data_q <= SPACE_BYTE;
          clr_cnt_q  <= clr_cnt_q - 16'd1;
          if (clr_cnt_q == 16'd1) state_q <= ST_IDLE;
        end
      end else if (pop) begin
        case (state_q)
          ST_IDLE: begin
            if (fifo_byte == ESC_BYTE) begin
              state_q <= ST_ESC;
            end else begin
              out_en_q   <= 1'b1;
              out_data_q <= fifo_byte;
            end
          end
          ST_ESC: begin
            case (fifo_byte)
              R_BYTE: state_q <= ST_ARG_R;
              C_BYTE: state_q <= ST_ARG_C;
              K_BYTE: begin
                state_q   <= ST_CLEAR;
                clr_cnt_q <= 16'(rows_q) * 16'(cols_q);
              end
              ESC_BYTE: begin
                out_en_q   <= 1'b1;
                out_data_q <= ESC_BYTE;
                state_q    <= ST_IDLE;
              end
              default: state_q <= ST_IDLE;
            endcase
          end
          ST_ARG_R: begin
            if (fifo_byte != 8'h00) begin
              rows_q   <= fifo_byte;
              update_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          ST_ARG_C: begin
            if (fifo_byte != 8'h00) begin
              cols_q   <= fifo_byte;
              update_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign out_data          = out_data_q;
  assign out_en            = out_en_q;
  assign max_rows          = rows_q;
  assign max_columns       = cols_q;
  assign row_column_update = update_q;
  assign overflow          = overflow_q;
  assign busy              = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb/tb_uart_cmd_sequencer.sv - directed self-checking bench for uart_cmd_sequencer
module tb_uart_cmd_sequencer;

  logic       CLK_50MHz = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] rx_data   = 8'h00;
  logic       rx_en     = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_en;
  logic [7:0] max_rows;
  logic [7:0] max_columns;
  logic       row_column_update;
  logic       overflow;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int upd_cnt = 0;
  logic [7:0] out_q [$];
  int out_cyc_q [$];

  uart_cmd_sequencer dut (
    .CLK_50MHz        (CLK_50MHz),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_en            (rx_en),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_en           (out_en),
    .max_rows         (max_rows),
    .max_columns      (max_columns),
    .row_column_update(row_column_update),
    .overflow         (overflow),
    .busy             (busy)
  );

  always #10 CLK_50MHz = ~CLK_50MHz;

  always @(posedge CLK_50MHz) cyc <= cyc + 1;

  always @(negedge CLK_50MHz) begin
    if (out_en) begin
      out_q.push_back(out_data);
      out_cyc_q.push_back(cyc);
    end
    if (row_column_update) upd_cnt = upd_cnt + 1;
  end

  task automatic tick();
    @(posedge CLK_50MHz);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_en   = 1'b1;
    tick();
    rx_en   = 1'b0;
  endtask

  task automatic clear_log();
    out_q.delete();
    out_cyc_q.delete();
    upd_cnt = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    clear_log();
  endtask

  task automatic test_reset();
    tick();
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want %h", out_data, 8'h00); end
    checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL reset_out_en: got %b want 0", out_en); end
    checks++; if (max_rows !== 8'h80) begin errors++; $display("FAIL reset_max_rows: got %h want 80", max_rows); end
    checks++; if (max_columns !== 8'hA0) begin errors++; $display("FAIL reset_max_columns: got %h want a0", max_columns); end
    checks++; if (row_column_update !== 1'b0) begin errors++; $display("FAIL reset_update: got %b want 0", row_column_update); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    clear_log();
  endtask

  task automatic test_forward();
    int c0;
    clear_log();
    c0 = cyc;
    send(8'h41);
    send(8'h42);
    idle(4);
    checks++; if (out_q.size() !== 2) begin errors++; $display("FAIL fwd_count: got %0d want 2", out_q.size()); end
    if (out_q.size() >= 2) begin
      checks++; if (out_q[0] !== 8'h41) begin errors++; $display("FAIL fwd_byte0: got %h want 41", out_q[0]); end
      checks++; if (out_q[1] !== 8'h42) begin errors++; $display("FAIL fwd_byte1: got %h want 42", out_q[1]); end
      checks++; if (out_cyc_q[0] - c0 !== 2) begin errors++; $display("FAIL fwd_latency: got %0d want 2", out_cyc_q[0] - c0); end
      checks++; if (out_cyc_q[1] - c0 !== 3) begin errors++; $display("FAIL fwd_latency2: got %0d want 3", out_cyc_q[1] - c0); end
    end
  endtask

  task automatic test_set_geometry();
    clear_log();
    send(8'h1B); send(8'h52); send(8'h20);
    idle(3);
    checks++; if (max_rows !== 8'h20) begin errors++; $display("FAIL geo_rows: got %h want 20", max_rows); end
    checks++; if (upd_cnt !== 1) begin errors++; $display("FAIL geo_rows_pulse: got %0d want 1", upd_cnt); end
    idle(5);
    send(8'h1B);
    idle(3);
    send(8'h43);
    idle(2);
    send(8'h28);
    idle(3);
    checks++; if (max_columns !== 8'h28) begin errors++; $display("FAIL geo_cols: got %h want 28", max_columns); end
    checks++; if (max_rows !== 8'h20) begin errors++; $display("FAIL geo_rows_kept: got %h want 20", max_rows); end
    checks++; if (upd_cnt !== 2) begin errors++; $display("FAIL geo_cols_pulse: got %0d want 2", upd_cnt); end
    checks++; if (out_q.size() !== 0) begin errors++; $display("FAIL geo_forwarded: got %0d want 0", out_q.size()); end
  endtask

  task automatic test_clear_small();
    int bad;
    send(8'h1B); send(8'h52); send(8'h02);
    send(8'h1B); send(8'h43); send(8'h03);
    idle(3);
    clear_log();
    send(8'h1B); send(8'h4B);
    for (int i = 0; i < 40; i++) begin
      out_ready = ~out_ready;
      tick();
    end
    out_ready = 1'b1;
    idle(2);
    bad = 0;
    foreach (out_q[i]) if (out_q[i] !== 8'h20) bad++;
    checks++; if (out_q.size() !== 6) begin errors++; $display("FAIL clr6_count: got %0d want 6", out_q.size()); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL clr6_data: got %0d non-space want 0", bad); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr6_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr6_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_escape_literal();
    apply_reset();
    send(8'h1B); send(8'h1B);
    idle(3);
    checks++; if (out_q.size() !== 1) begin errors++; $display("FAIL esc_lit_count: got %0d want 1", out_q.size()); end
    if (out_q.size() >= 1) begin
      checks++; if (out_q[0] !== 8'h1B) begin errors++; $display("FAIL esc_lit_byte: got %h want 1b", out_q[0]); end
    end
    send(8'h1B); send(8'h52); send(8'h00);
    idle(3);
    checks++; if (max_rows !== 8'h80) begin errors++; $display("FAIL zero_rows: got %h want 80", max_rows); end
    checks++; if (upd_cnt !== 0) begin errors++; $display("FAIL zero_rows_pulse: got %0d want 0", upd_cnt); end
    send(8'h1B); send(8'h5A);
    idle(3);
    checks++; if (out_q.size() !== 1) begin errors++; $display("FAIL esc_discard: got %0d want 1", out_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL esc_busy: got %b want 0", busy); end
  endtask

  task automatic test_clear_overflow();
    int n;
    int bad;
    apply_reset();
    send(8'h1B); send(8'h4B);
    for (int i = 0; i < 6; i++) send(8'h61 + 8'(i));
    idle(1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n = 0;
    while (out_q.size() < 20484 && n < 21000) begin
      tick();
      n++;
    end
    idle(4);
    checks++; if (out_q.size() !== 20484) begin errors++; $display("FAIL ovf_total: got %0d want 20484", out_q.size()); end
    if (out_q.size() >= 20484) begin
      bad = 0;
      for (int i = 0; i < 20480; i++) if (out_q[i] !== 8'h20) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL ovf_spaces: got %0d non-space want 0", bad); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_q[20480+i] !== 8'h61 + 8'(i)) begin
          errors++; $display("FAIL ovf_tail%0d: got %h want %h", i, out_q[20480+i], 8'h61 + 8'(i));
        end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_clear();
    int c0;
    apply_reset();
    send(8'h1B); send(8'h4B);
    idle(10);
    checks++; if (out_q.size() == 0) begin errors++; $display("FAIL rst_clear_started: got 0 want >0 spaces"); end
    reset = 1'b1;
    tick();
    checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL rst_out_en: got %b want 0", out_en); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h want 00", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (max_rows !== 8'h80 || max_columns !== 8'hA0) begin
      errors++; $display("FAIL rst_geometry: got %h/%h want 80/a0", max_rows, max_columns);
    end
    checks++; if (overflow !== 1'b0 || row_column_update !== 1'b0) begin
      errors++; $display("FAIL rst_flags: got ovf=%b upd=%b want 0/0", overflow, row_column_update);
    end
    reset = 1'b0;
    clear_log();
    c0 = cyc;
    send(8'h41);
    idle(4);
    checks++; if (out_q.size() !== 1) begin errors++; $display("FAIL rst_after_count: got %0d want 1", out_q.size()); end
    if (out_q.size() >= 1) begin
      checks++; if (out_q[0] !== 8'h41) begin errors++; $display("FAIL rst_after_byte: got %h want 41", out_q[0]); end
      checks++; if (out_cyc_q[0] - c0 !== 2) begin errors++; $display("FAIL rst_after_latency: got %0d want 2", out_cyc_q[0] - c0); end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_set_geometry();
    test_clear_small();
    test_escape_literal();
    test_clear_overflow();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
